// File: rtl/smac_pkg.sv
// Shared types and helpers for the SMAC feeder and the parallel datapath it drives.
package smac_pkg;

   // Feeder sequencing: gather lanes, load a vector, optionally load a zero vector.
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Default geometry of the datapath.
   localparam int M_DEF  = 64;
   localparam int PA_DEF = 8;
   localparam int PW_DEF = 4;

   // Width of a lane counter that indexes m lanes.
   function automatic int cnt_width(input int m);
      return $clog2(m);
   endfunction

   // Lane-packed vectors as seen by the datapath, lane i in slice [i].
   typedef logic [M_DEF-1:0][PA_DEF-1:0] act_vec_t;
   typedef logic [M_DEF-1:0][PW_DEF-1:0] wei_vec_t;

endpackage

// File: rtl/smac_feeder.sv
// Packs a serial (activation, weight) stream into M-lane vectors for the SMAC
// datapath, follows each dot product with a zero-vector flush load, and marks
// the cycles in which the datapath's par_sum holds a real result.
module smac_feeder
   import smac_pkg::*;
#(
   parameter int M  = 64,
   parameter int Pa = 8,
   parameter int Pw = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [Pa-1:0]   s_act,
   input  logic [Pw-1:0]   s_wei,
   input  logic            s_last,
   output logic [M*Pa-1:0] in_act,
   output logic [M*Pw-1:0] in_wei,
   output logic            w_en,
   output logic            sum_valid,
   output logic            sum_last,
   output logic            busy
);

   localparam int CW = cnt_width(M);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic                vlast;
   logic                pend, pend_last;
   logic [M-1:0][Pa-1:0] act_q;
   logic [M-1:0][Pw-1:0] wei_q;
   logic                accept;
   logic                vec_done;

   // Acceptance is decoded from the state directly so it never loops through s_ready.
   assign accept   = s_valid && (state == FILL);
   assign vec_done = accept && ((cnt == CW'(M - 1)) || s_last);

   // The staging registers double as the datapath-facing vector outputs.
   assign in_act = act_q;
   assign in_wei = wei_q;
   assign busy   = (state != FILL) || (cnt != '0) || pend;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block ordering.
         state <= state_nxt;
      end
   end

   // Next-state and handshake/load decode.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      state_nxt = state;
      s_ready   = 1'b0;
      w_en      = 1'b0;
      unique case (state)
         FILL: begin
            s_ready = 1'b1;
            if (vec_done) state_nxt = ISSUE;
         end
         ISSUE: begin
            w_en      = 1'b1;
            state_nxt = vlast ? FLUSH : FILL;
         end
         FLUSH: begin
            w_en      = 1'b1;
            state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // Lane staging: write accepted elements, clear to the zero vector once issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         vlast <= 1'b0;
         act_q <= '0;
         wei_q <= '0;
      end else if (state == ISSUE) begin
         cnt   <= '0;
         act_q <= '0;
         wei_q <= '0;
      end else if (accept) begin
         act_q[cnt] <= s_act;
         wei_q[cnt] <= s_wei;
         if (vec_done) begin
            cnt   <= '0;
            vlast <= s_last;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Result tracking: a vector's sum reaches par_sum one load after its own load,
   // so the pending flag is carried across exactly one w_en edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         pend_last <= 1'b0;
         sum_valid <= 1'b0;
         sum_last  <= 1'b0;
      end else if (w_en) begin
         sum_valid <= pend;
         sum_last  <= pend_last;
         pend      <= (state == ISSUE);
         pend_last <= (state == ISSUE) && vlast;
      end else begin
         sum_valid <= 1'b0;
         sum_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_smac_feeder.sv
// Bench for smac_feeder with a behavioural SMAC datapath behind it: the
// datapath's input and par_sum registers share w_en, as in the real block.
module tb_smac_feeder;

   localparam int M  = 4;
   localparam int PA = 8;
   localparam int PW = 4;
   localparam int NR = 60;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            s_valid, s_ready, s_last;
   logic [PA-1:0]   s_act;
   logic [PW-1:0]   s_wei;
   logic [M*PA-1:0] in_act;
   logic [M*PW-1:0] in_wei;
   logic            w_en, sum_valid, sum_last, busy;

   always #5 clk = ~clk;

   smac_feeder #(.M(M), .Pa(PA), .Pw(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wei(s_wei), .s_last(s_last),
      .in_act(in_act), .in_wei(in_wei), .w_en(w_en),
      .sum_valid(sum_valid), .sum_last(sum_last), .busy(busy)
   );

   // Behavioural datapath.
   logic [M*PA-1:0] dp_act;
   logic [M*PW-1:0] dp_wei;
   int              par_sum;

   function automatic int dot(input logic [M*PA-1:0] a, input logic [M*PW-1:0] w);
      int s = 0;
      for (int i = 0; i < M; i++) s += int'(a[i*PA +: PA]) * int'(w[i*PW +: PW]);
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_act  <= '0;
         dp_wei  <= '0;
         par_sum <= 0;
      end else if (w_en) begin
         par_sum <= dot(dp_act, dp_wei);
         dp_act  <= in_act;
         dp_wei  <= in_wei;
      end
   end

   typedef struct {
      int sum;
      bit last;
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];

   // Record every result the datapath presents.
   always @(negedge clk) begin
      if (rst_n && sum_valid === 1'b1) obs_q.push_back(ev_t'{sum: par_sum, last: sum_last});
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the element is accepted.
   task automatic send(input logic [PA-1:0] a, input logic [PW-1:0] w, input logic l);
      int n = 0;
      s_valid = 1'b1;
      s_act   = a;
      s_wei   = w;
      s_last  = l;
      while (s_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("send_timeout", 64'(n), 64'(0));
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("idle_timeout", 64'(busy), 64'(0));
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      int           n;
      logic [63:0]  acts;
      logic [31:0]  weis;
      int           nvec;
      int           sum0;
      bit           last0;
      int           sum1;
      bit           last1;
   } rec_t;

   rec_t tbl[7];

   logic [PA-1:0] ra[NR];
   logic [PW-1:0] rw[NR];
   logic          rl[NR];

   initial begin
      int acc, fill, nlast, i, cyc, nwen;
      logic r;

      s_valid = 1'b0; s_act = '0; s_wei = '0; s_last = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_s_ready", 64'(s_ready), 64'(1));
      check("rst_w_en", 64'(w_en), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_in_act", 64'(in_act), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_s_ready", 64'(s_ready), 64'(1));
      check("idle_w_en", 64'(w_en), 64'(0));
      check("idle_sum_valid", 64'(sum_valid), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_in_act", 64'(in_act), 64'(0));
      check("idle_in_wei", 64'(in_wei), 64'(0));

      // Exact cycle timing of one full vector that closes a dot product.
      obs_q.delete();
      send(8'd1, 4'd1, 1'b0);
      send(8'd2, 4'd1, 1'b0);
      send(8'd3, 4'd1, 1'b0);
      send(8'd4, 4'd1, 1'b1);
      check("issue_w_en", 64'(w_en), 64'(1));
      check("issue_s_ready", 64'(s_ready), 64'(0));
      check("issue_in_act", 64'(in_act), 64'h04030201);
      check("issue_in_wei", 64'(in_wei), 64'h1111);
      check("issue_busy", 64'(busy), 64'(1));
      @(negedge clk);
      check("flush_w_en", 64'(w_en), 64'(1));
      check("flush_s_ready", 64'(s_ready), 64'(0));
      check("flush_in_act", 64'(in_act), 64'(0));
      check("flush_sum_valid", 64'(sum_valid), 64'(0));
      @(negedge clk);
      check("res_w_en", 64'(w_en), 64'(0));
      check("res_sum_valid", 64'(sum_valid), 64'(1));
      check("res_sum_last", 64'(sum_last), 64'(1));
      check("res_par_sum", 64'(par_sum), 64'(10));
      @(negedge clk);
      check("res_pulse_end", 64'(sum_valid), 64'(0));
      check("res_busy", 64'(busy), 64'(0));

      // Single element: lanes 1..M-1 padded with zero.
      obs_q.delete();
      send(8'd7, 4'd3, 1'b1);
      check("single_in_act", 64'(in_act), 64'h00000007);
      check("single_in_wei", 64'(in_wei), 64'h0003);
      repeat (2) @(negedge clk);
      check("single_sum_valid", 64'(sum_valid), 64'(1));
      check("single_sum_last", 64'(sum_last), 64'(1));
      check("single_par_sum", 64'(par_sum), 64'(21));
      wait_idle();

      // Table of dot products with hand-computed per-vector sums.
      tbl[0] = '{4, 64'h04030201,          32'h00001111, 1, 10,    1'b1, 0,  1'b0};
      tbl[1] = '{8, 64'h05050505_04030201, 32'h11112222, 2, 20,    1'b0, 20, 1'b1};
      tbl[2] = '{1, 64'h07,                32'h00000003, 1, 21,    1'b1, 0,  1'b0};
      tbl[3] = '{3, 64'h040302,            32'h00000765, 1, 56,    1'b1, 0,  1'b0};
      tbl[4] = '{5, 64'h05_04030201,       32'h00011111, 2, 10,    1'b0, 5,  1'b1};
      tbl[5] = '{4, 64'hFFFFFFFF,          32'h0000FFFF, 1, 15300, 1'b1, 0,  1'b0};
      tbl[6] = '{6, 64'h0A09_08070605,     32'h00214321, 2, 70,    1'b0, 29, 1'b1};
      for (int t = 0; t < 7; t++) begin
         obs_q.delete();
         for (int e = 0; e < tbl[t].n; e++)
            send(tbl[t].acts[e*8 +: 8], tbl[t].weis[e*4 +: 4], e == tbl[t].n - 1);
         wait_idle();
         check($sformatf("tbl%0d_count", t), 64'(obs_q.size()), 64'(tbl[t].nvec));
         if (obs_q.size() >= 1) begin
            check($sformatf("tbl%0d_sum0", t), 64'(obs_q[0].sum), 64'(tbl[t].sum0));
            check($sformatf("tbl%0d_last0", t), 64'(obs_q[0].last), 64'(tbl[t].last0));
         end
         if (obs_q.size() >= 2 && tbl[t].nvec >= 2) begin
            check($sformatf("tbl%0d_sum1", t), 64'(obs_q[1].sum), 64'(tbl[t].sum1));
            check($sformatf("tbl%0d_last1", t), 64'(obs_q[1].last), 64'(tbl[t].last1));
         end
      end

      // Reset in the middle of a vector discards the partial data.
      send(8'd9, 4'd9, 1'b0);
      send(8'd9, 4'd9, 1'b0);
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rstmid_w_en", 64'(w_en), 64'(0));
         check("rstmid_in_act", 64'(in_act), 64'(0));
      end
      check("rstmid_busy", 64'(busy), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      obs_q.delete();
      for (int e = 0; e < 4; e++) send(8'd1, 4'd1, e == 3);
      wait_idle();
      check("rstmid_count", 64'(obs_q.size()), 64'(1));
      if (obs_q.size() >= 1) begin
         check("rstmid_sum", 64'(obs_q[0].sum), 64'(4));
         check("rstmid_last", 64'(obs_q[0].last), 64'(1));
      end

      // Randomized stream with s_valid held high; reference sums from plain arithmetic.
      exp_q.delete();
      acc = 0; fill = 0; nlast = 0;
      for (int k = 0; k < NR; k++) begin
         ra[k] = PA'($urandom_range(255, 0));
         rw[k] = PW'($urandom_range(15, 0));
         rl[k] = (k == NR - 1) || ($urandom_range(4, 0) == 0);
         acc  += int'(ra[k]) * int'(rw[k]);
         fill++;
         if (fill == M || rl[k]) begin
            exp_q.push_back(ev_t'{sum: acc, last: rl[k]});
            acc  = 0;
            fill = 0;
         end
         if (rl[k]) nlast++;
      end

      obs_q.delete();
      i = 0; cyc = 0; nwen = 0;
      s_valid = 1'b1; s_act = ra[0]; s_wei = rw[0]; s_last = rl[0];
      while ((i < NR || busy === 1'b1) && cyc < 2000) begin
         r = s_ready;
         check("rand_ready_vs_wen", 64'(s_ready), 64'(!w_en));
         if (w_en === 1'b1) nwen++;
         @(negedge clk);
         cyc++;
         if (r && i < NR) i++;
         if (i < NR) begin
            s_act = ra[i]; s_wei = rw[i]; s_last = rl[i];
         end else begin
            s_valid = 1'b0; s_last = 1'b0;
         end
      end
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rand_accepted", 64'(i), 64'(NR));
      check("rand_wen_cycles", 64'(nwen), 64'(exp_q.size() + nlast));
      check("rand_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         check($sformatf("rand_sum%0d", k), 64'(obs_q[k].sum), 64'(exp_q[k].sum));
         check($sformatf("rand_last%0d", k), 64'(obs_q[k].last), 64'(exp_q[k].last));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/smac_feeder.md
Name: smac_feeder

Overview:
- Writer-side front end for the parallel SMAC datapath.
- Accepts a serial valid/ready stream of (activation, weight) pairs and packs them into M-lane vectors.
- Drives the datapath's in_act/in_wei/w_en interface.
- Because the datapath's input and output registers share one write enable, the block also issues zero-vector flush pulses and generates sum_valid/sum_last, time-aligned with the datapath's par_sum.

Parameters:
M, 64, number of lanes per vector (power of two, >=2)
Pa, 8, activation width
Pw, 4, weight width

Ports:
clk  in  1  clock
rst_n  in  1  reset
s_valid  in  1  input element valid
s_ready  out  1  block can accept an element this cycle
s_act  in  Pa  activation element
s_wei  in  Pw  weight element
s_last  in  1  element is the final one of a dot product
in_act  out  M*Pa  packed activation vector to datapath, lane i = element i
in_wei  out  M*Pw  packed weight vector to datapath
w_en  out  1  one-cycle load pulse to datapath
sum_valid  out  1  datapath par_sum holds the sum of a real data vector this cycle
sum_last  out  1  qualifies sum_valid: that vector closed a dot product
busy  out  1  state != FILL or lane count != 0 or pend

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=FILL, lane count cnt=0, s_ready=1.
  - in_act/in_wei all zero.
  - w_en, sum_valid, sum_last, busy all 0.
  - Internal pend=0, pend_last=0.
  - Reset mid-vector discards all partial data; no w_en is issued.
- Accept: handshake = s_valid && s_ready.
  - On accept, lane cnt of in_act/in_wei takes s_act/s_wei.
  - cnt increments, or wraps to 0 when the vector completes.
- Vector complete: accept with cnt==M-1 or s_last=1.
  - Unwritten lanes keep zero, i.e. zero padding.
  - Latch vlast=s_last, then go to ISSUE.
- States:
  - FILL: s_ready=1, w_en=0.
  - ISSUE (1 cycle): w_en=1, s_ready=0; vector outputs hold the staged data.
    - At the clock edge, clear in_act/in_wei to zero and set cnt=0.
    - Next state: FLUSH if vlast, else FILL.
  - FLUSH (1 cycle): w_en=1 with the zero vector, s_ready=0. Next state: FILL.
- Sum tracking, updated on every edge where w_en=1:
  - sum_valid <= pend; sum_last <= pend_last.
  - pend <= (state==ISSUE); pend_last <= (state==ISSUE && vlast).
  - On edges where w_en=0: sum_valid <= 0 and sum_last <= 0, so both are one-cycle pulses.
- Alignment with the datapath:
  - Vector n is loaded into the datapath input registers on its ISSUE edge.
  - Its sum enters par_sum on the next w_en edge (next ISSUE or the FLUSH).
  - sum_valid is high in the cycle immediately after that edge, exactly when par_sum is valid.
  - A FLUSH pulse never produces sum_valid for itself.
- Throughput: a full vector costs M accept cycles + 1 ISSUE cycle. A dot product adds 1 FLUSH cycle.
- s_last with cnt==0: single-element vector; lanes 1..M-1 are zero.
- s_last on lane M-1: one ISSUE, then FLUSH; no extra empty vector.
- s_valid while s_ready=0 has no effect. Upstream holds data per the valid/ready rule.
- Widths: cnt is $clog2(M) bits. No arithmetic on data; values pass through unchanged.

Decomposition:
- Shared package smac_pkg:
  - state enum {FILL, ISSUE, FLUSH}.
  - localparam function for lane-counter width ($clog2(M)).
  - Vector typedefs: act_vec_t [M-1:0][Pa-1:0] and wei_vec_t [M-1:0][Pw-1:0], shared with the datapath.
- Single module; no sub-module. The staging registers are the output registers.

Test Plan (M=4, Pa=8, Pw=4 unless stated; datapath instantiated behind the feeder):
- Reset then idle -> s_ready=1; w_en, sum_valid, busy = 0; in_act=0.
- Stream acts 1,2,3,4 with weights 1,1,1,1, last on 4th element -> ISSUE w_en then FLUSH w_en; sum_valid and sum_last pulse one cycle after FLUSH edge; par_sum=10 in that cycle.
- Two back-to-back vectors (1,2,3,4 · 2,2,2,2) then (5,5,5,5 · 1,1,1,1, last) -> sum_valid after 2nd ISSUE with par_sum=20 and sum_last=0; then sum_valid after FLUSH with par_sum=20 and sum_last=1.
- Single element act=7, wei=3, last -> in_act = {0,0,0,7} during ISSUE; par_sum=21 with sum_valid=1, sum_last=1.
- s_valid held high continuously -> s_ready low exactly in ISSUE/FLUSH cycles; no element lost or duplicated (scoreboard compares sums).
- Assert rst_n=0 after 2 of 4 elements, then release and send act 1,1,1,1 with weight 1,1,1,1, last -> no w_en during reset; par_sum=4 with no residue from the discarded elements.
